// File: rtl/digit_sequencer.sv
// Digit source for the 7-segment decoder: a prescaled up/down digit counter
// with wrap at MAX_DIGIT, run/pause from a debounced button, and a sync clear.
module digit_sequencer #(
    parameter int TICK_DIV   = 50000000,
    parameter int MAX_DIGIT  = 9,
    parameter int DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_btn,
    input  logic       dir,
    input  logic       clear,
    output logic [3:0] digit,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [3:0]    DIGIT_MAX  = 4'(MAX_DIGIT);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_btn_acc;
    logic          r_btn_prev;
    logic [DW-1:0] r_deb_cnt;
    logic          r_running;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_digit;
    logic          r_tick;
    logic          r_wrap;

    logic          w_press;
    logic          w_step;
    logic [3:0]    w_next_digit;
    logic          w_next_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= run_btn;
            r_sync2 <= r_sync1;
        end
    end

    // A new level is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_acc  <= 1'b0;
            r_btn_prev <= 1'b0;
            r_deb_cnt  <= '0;
        end else begin
            r_btn_prev <= r_btn_acc;
            if (r_sync2 == r_btn_acc) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_btn_acc <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    assign w_press = r_btn_acc & ~r_btn_prev;
    assign w_step  = r_running && (r_presc == PRESC_LAST);

    always_comb begin
        w_next_digit = r_digit;
        w_next_wrap  = 1'b0;
        if (dir) begin
            if (r_digit >= DIGIT_MAX) begin
                w_next_digit = '0;
                w_next_wrap  = 1'b1;
            end else begin
                w_next_digit = r_digit + 4'd1;
            end
        end else begin
            if (r_digit == 4'd0) begin
                w_next_digit = DIGIT_MAX;
                w_next_wrap  = 1'b1;
            end else begin
                w_next_digit = r_digit - 4'd1;
            end
        end
    end

    // Step decisions use the pre-toggle running value; clear overrides a coincident step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_running <= 1'b0;
            r_presc   <= '0;
            r_digit   <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            if (w_press) begin
                r_running <= ~r_running;
            end
            if (clear) begin
                r_presc <= '0;
                r_digit <= '0;
                r_tick  <= 1'b0;
                r_wrap  <= 1'b0;
            end else if (w_step) begin
                r_presc <= '0;
                r_digit <= w_next_digit;
                r_tick  <= 1'b1;
                r_wrap  <= w_next_wrap;
            end else begin
                r_tick <= 1'b0;
                r_wrap <= 1'b0;
                if (r_running) begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    assign digit   = r_digit;
    assign running = r_running;
    assign tick    = r_tick;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench for digit_sequencer: a cycle table for start-up and clear,
// then hand-written sequences for wrap, pause/resume, glitches and reset.
module tb_digit_sequencer;

    logic       clk;
    logic       rst;
    logic       run_btn;
    logic       dir;
    logic       clear;
    logic [3:0] digit;
    logic       running;
    logic       tick;
    logic       wrap;

    int n_pass;
    int n_total;

    digit_sequencer #(
        .TICK_DIV  (4),
        .MAX_DIGIT (9),
        .DEB_CYCLES(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .run_btn(run_btn),
        .dir    (dir),
        .clear  (clear),
        .digit  (digit),
        .running(running),
        .tick   (tick),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic       d;
        logic       clr;
        logic [3:0] e_digit;
        logic       e_tick;
        logic       e_wrap;
        logic       e_run;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic cyc(input logic b, input logic d, input logic c);
        run_btn = b;
        dir     = d;
        clear   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input logic d, input int maxc, output int n);
        n = 0;
        do begin
            cyc(1'b0, d, 1'b0);
            n++;
        end while (!tick && n < maxc);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int exp_d;
        int m_presc;
        int exp_t;
        int exp_w;
        int n_ticks;
        int n_wraps;

        n_pass  = 0;
        n_total = 0;

        // rows 1..18: clean press from digit 0; row 19: clear with running kept
        for (int i = 0; i < 19; i++) begin
            vecs[i].btn = (i < 10) ? 1'b1 : 1'b0;
            vecs[i].d   = 1'b1;
            vecs[i].clr = (i == 18) ? 1'b1 : 1'b0;
            vecs[i].e_run  = (i >= 5) ? 1'b1 : 1'b0;
            vecs[i].e_wrap = 1'b0;
            vecs[i].e_tick = (i == 9 || i == 13 || i == 17) ? 1'b1 : 1'b0;
            vecs[i].e_digit = (i < 9) ? 4'd0 : (i < 13) ? 4'd1 :
                              (i < 17) ? 4'd2 : (i == 17) ? 4'd3 : 4'd0;
        end

        rst = 1'b1;
        run_btn = 1'b0;
        dir = 1'b1;
        clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_digit", int'(digit), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_tick", int'(tick), 0);
        chk("reset_wrap", int'(wrap), 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].btn, vecs[i].d, vecs[i].clr);
            chk($sformatf("vec%0d_digit", i + 1), int'(digit), int'(vecs[i].e_digit));
            chk($sformatf("vec%0d_tick", i + 1), int'(tick), int'(vecs[i].e_tick));
            chk($sformatf("vec%0d_wrap", i + 1), int'(wrap), int'(vecs[i].e_wrap));
            chk($sformatf("vec%0d_running", i + 1), int'(running), int'(vecs[i].e_run));
        end

        // count up 40 cycles from 0 with an independent cycle model
        exp_d = 0;
        m_presc = 0;
        n_ticks = 0;
        n_wraps = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b0, 1'b1, 1'b0);
            exp_t = 0;
            exp_w = 0;
            if (m_presc == 3) begin
                m_presc = 0;
                exp_t = 1;
                exp_w = (exp_d == 9) ? 1 : 0;
                exp_d = (exp_d == 9) ? 0 : exp_d + 1;
            end else begin
                m_presc++;
            end
            if (tick) n_ticks++;
            if (wrap) n_wraps++;
            chk($sformatf("up%0d_digit", c), int'(digit), exp_d);
            chk($sformatf("up%0d_tick", c), int'(tick), exp_t);
            chk($sformatf("up%0d_wrap", c), int'(wrap), exp_w);
        end
        chk("up_tick_count", n_ticks, 10);
        chk("up_wrap_count", n_wraps, 1);

        // count down from 0: wrap to 9, then 8 without wrap
        wait_tick(1'b0, 12, n);
        chk("down_first_wait", n, 4);
        chk("down_first_digit", int'(digit), 9);
        chk("down_first_wrap", int'(wrap), 1);
        wait_tick(1'b0, 12, n);
        chk("down_second_wait", n, 4);
        chk("down_second_digit", int'(digit), 8);
        chk("down_second_wrap", int'(wrap), 0);

        // press to pause; toggle lands with prescaler at 2 after the 8->7 step
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 1'b0);
        chk("pause_step_tick", int'(tick), 1);
        chk("pause_step_digit", int'(digit), 7);
        cyc(1'b1, 1'b0, 1'b0);
        chk("pause_before_toggle", int'(running), 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("pause_toggle", int'(running), 0);
        for (int c = 0; c < 20; c++) begin
            cyc((c < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            chk($sformatf("paused%0d_tick", c), int'(tick), 0);
            chk($sformatf("paused%0d_digit", c), int'(digit), 7);
        end
        chk("paused_after_release", int'(running), 0);

        // glitchy button: never stable for 3 cycles
        begin
            logic [11:0] glitch;
            glitch = 12'b000000011011;
            for (int c = 0; c < 12; c++) begin
                cyc(glitch[c], 1'b0, 1'b0);
                chk($sformatf("glitch%0d_running", c), int'(running), 0);
                chk($sformatf("glitch%0d_tick", c), int'(tick), 0);
            end
        end

        // clean 3-cycle press resumes; prescaler continues from 2
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resume_before_toggle", int'(running), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resume_toggle", int'(running), 1);
        wait_tick(1'b0, 12, n);
        chk("resume_first_step_wait", n, 2);
        chk("resume_first_step_digit", int'(digit), 6);

        // clear on the step edge while digit is 5
        wait_tick(1'b0, 12, n);
        chk("pre_clear_wait", n, 4);
        chk("pre_clear_digit", int'(digit), 5);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("pre_clear%0d_tick", c), int'(tick), 0);
        end
        cyc(1'b0, 1'b1, 1'b1);
        chk("clear_digit", int'(digit), 0);
        chk("clear_tick", int'(tick), 0);
        chk("clear_wrap", int'(wrap), 0);
        chk("clear_running", int'(running), 1);
        wait_tick(1'b1, 12, n);
        chk("post_clear_wait", n, 4);
        chk("post_clear_digit", int'(digit), 1);
        chk("post_clear_wrap", int'(wrap), 0);

        // asynchronous reset mid-cycle clears outputs before any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_digit", int'(digit), 0);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_wrap", int'(wrap), 0);
        cyc(1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) cyc(1'b0, 1'b1, 1'b0);
        chk("after_rst_running", int'(running), 0);
        chk("after_rst_digit", int'(digit), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
